// File: rtl/icache_responder.sv
// Direct-mapped instruction cache: answers fetch line requests, fills misses from a 32-bit memory bus.
// Latency: hit -> icache_ready 1 cycle after icache_en is sampled; miss -> 1 + cycles for 4 mem_ack beats.
// Backpressure: icache_en is held by the requester until the ready pulse; a fill waits indefinitely on mem_ack.
//
// Ports:
//   clk, reset (async, active-low)
//   icache_en / icache_address / flush          : request side inputs
//   icache_data / icache_ready                  : 128-bit line and one-cycle valid pulse
//   mem_req / mem_addr / mem_ack / mem_data     : word-wide line fill bus
module icache_responder #(
   parameter int NUM_LINES  = 8,
   parameter int INDEX_BITS = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         icache_en,
   input  logic [31:0]  icache_address,
   input  logic         flush,
   output logic [127:0] icache_data,
   output logic         icache_ready,
   output logic         mem_req,
   output logic [31:0]  mem_addr,
   input  logic         mem_ack,
   input  logic [31:0]  mem_data
);

   localparam int TAG_BITS = 32 - INDEX_BITS - 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [1:0]           beat_q, beat_d;
   logic [27:0]          req_addr_q, req_addr_d;
   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic                 flush_pending_q, flush_pending_d;
   logic [95:0]          line_buf_q, line_buf_d;
   logic [127:0]         icache_data_q, icache_data_d;

   // Tag and data storage carry no reset; the valid bits alone decide a hit.
   logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
   logic [127:0]         data_mem [NUM_LINES];

   logic                  arr_we;
   logic [127:0]          fill_line;
   logic [INDEX_BITS-1:0] lookup_idx;
   logic [TAG_BITS-1:0]   lookup_tag;
   logic [INDEX_BITS-1:0] fill_idx;
   logic [TAG_BITS-1:0]   fill_tag;
   logic                  lookup_hit;

   // Requests are line aligned, so the byte offset never participates.
   logic unused_addr_bits;
   assign unused_addr_bits = ^icache_address[3:0];

   assign lookup_idx = icache_address[INDEX_BITS+3:4];
   assign lookup_tag = icache_address[31:INDEX_BITS+4];
   assign fill_idx   = req_addr_q[INDEX_BITS-1:0];
   assign fill_tag   = req_addr_q[27:INDEX_BITS];
   assign lookup_hit = valid_q[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);

   // The last beat goes straight into the response and the array, not via line_buf.
   assign fill_line  = {mem_data, line_buf_q};

   always_comb begin
      state_d         = state_q;
      beat_d          = beat_q;
      req_addr_d      = req_addr_q;
      valid_d         = valid_q;
      flush_pending_d = flush_pending_q;
      line_buf_d      = line_buf_q;
      icache_data_d   = icache_data_q;
      arr_we          = 1'b0;

      // A coincident lookup still sees valid_q, i.e. the pre-flush valids.
      if (flush) begin
         valid_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (icache_en) begin
               req_addr_d = icache_address[31:4];
               if (lookup_hit) begin
                  icache_data_d = data_mem[lookup_idx];
                  state_d       = ST_RESP;
               end else begin
                  beat_d          = 2'd0;
                  flush_pending_d = 1'b0;
                  state_d         = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            if (flush) begin
               flush_pending_d = 1'b1;
            end
            if (mem_ack) begin
               beat_d = beat_q + 2'd1;
               case (beat_q)
                  2'd0: line_buf_d[31:0]  = mem_data;
                  2'd1: line_buf_d[63:32] = mem_data;
                  2'd2: line_buf_d[95:64] = mem_data;
                  default: begin
                     arr_we        = 1'b1;
                     icache_data_d = fill_line;
                     // A flush anywhere in this fill (including this edge) leaves the line invalid.
                     if (!flush_pending_q && !flush) begin
                        valid_d[fill_idx] = 1'b1;
                     end
                     flush_pending_d = 1'b0;
                     state_d         = ST_RESP;
                  end
               endcase
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= ST_IDLE;
         beat_q          <= 2'd0;
         req_addr_q      <= '0;
         valid_q         <= '0;
         flush_pending_q <= 1'b0;
         line_buf_q      <= '0;
         icache_data_q   <= '0;
      end else begin
         state_q         <= state_d;
         beat_q          <= beat_d;
         req_addr_q      <= req_addr_d;
         valid_q         <= valid_d;
         flush_pending_q <= flush_pending_d;
         line_buf_q      <= line_buf_d;
         icache_data_q   <= icache_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (arr_we) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= fill_line;
      end
   end

   assign icache_ready = (state_q == ST_RESP);
   assign mem_req      = (state_q == ST_FILL);
   assign mem_addr     = mem_req ? {req_addr_q, beat_q, 2'b00} : 32'd0;
   assign icache_data  = icache_data_q;

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: table of lookups with expected hit/miss, latency and line data,
// a memory responder with programmable stall, and a scoreboard checked on every ready pulse.
// Hand sequences cover back-to-back requests and reset in the middle of a fill.
module tb_icache_responder;

   logic         clk = 1'b0;
   logic         reset;
   logic         icache_en;
   logic [31:0]  icache_address;
   logic         flush;
   logic [127:0] icache_data;
   logic         icache_ready;
   logic         mem_req;
   logic [31:0]  mem_addr;
   logic         mem_ack;
   logic [31:0]  mem_data;

   icache_responder #(.NUM_LINES(8), .INDEX_BITS(3)) dut (
      .clk            (clk),
      .reset          (reset),
      .icache_en      (icache_en),
      .icache_address (icache_address),
      .flush          (flush),
      .icache_data    (icache_data),
      .icache_ready   (icache_ready),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_data       (mem_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Memory contents: the 0x123x line holds the 0x11111111.. pattern, other words derive from the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] k;
      k = 32'h11111111;
      if (a[31:4] == 28'h0000123)
         return k * ({30'd0, a[3:2]} + 32'd1);
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [127:0] exp_line(input logic [31:0] a);
      logic [127:0] l;
      for (int b = 0; b < 4; b++)
         l[32*b +: 32] = mem_word({a[31:4], b[1:0], 2'b00});
      return l;
   endfunction

   // Memory responder: checks the beat address each requesting cycle, acks after stall_cycles idle cycles.
   int         stall_cycles = 0;
   logic [27:0] cur_line = '0;
   logic [1:0]  mbeat = '0;

   initial begin
      int stall_cnt;
      stall_cnt = 0;
      mem_ack   = 1'b0;
      mem_data  = '0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            chk("mem_addr", {96'd0, mem_addr}, {96'd0, cur_line, mbeat, 2'b00});
            if (stall_cnt >= stall_cycles) begin
               stall_cnt = 0;
               mem_ack   = 1'b1;
               mem_data  = mem_word(mem_addr);
               @(posedge clk);
               #1;
               mem_ack   = 1'b0;
               mbeat     = mbeat + 2'd1;
            end else begin
               stall_cnt++;
            end
         end else begin
            stall_cnt = 0;
         end
      end
   end

   // Scoreboard: expected lines are queued when a request is driven, popped on each ready pulse.
   logic [127:0] sb_q[$];

   initial begin
      forever begin
         @(negedge clk);
         if (reset && icache_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_ready", 128'd1, 128'd0);
            end else begin
               chk("icache_data", icache_data, sb_q.pop_front());
            end
         end
      end
   end

   // fmode: 0 none, 1 flush in IDLE before the request, 2 flush on the lookup edge, 3 flush during beat 2
   typedef struct {
      logic [31:0]  addr;
      int           stall;
      int           fmode;
      bit           hit;
      logic [127:0] data;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] a, input int s, input int f, input bit h);
      vec_t v;
      v.addr  = a;
      v.stall = s;
      v.fmode = f;
      v.hit   = h;
      v.data  = exp_line(a);
      return v;
   endfunction

   task automatic do_req(input vec_t v);
      int n;
      int reqc;
      bit done;
      bit fl_done;
      int exp_lat;
      if (v.fmode == 1) begin
         flush = 1'b1;
         @(negedge clk);
         flush = 1'b0;
      end
      stall_cycles = v.stall;
      cur_line     = v.addr[31:4];
      mbeat        = 2'd0;
      sb_q.push_back(v.data);
      icache_en      = 1'b1;
      icache_address = v.addr;
      if (v.fmode == 2)
         flush = 1'b1;
      n = 0; reqc = 0; done = 1'b0; fl_done = 1'b0;
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
         flush = 1'b0;
         if (mem_req)
            reqc++;
         if (v.fmode == 3 && !fl_done && mem_req && mem_addr[3:2] == 2'd2) begin
            flush   = 1'b1;
            fl_done = 1'b1;
         end
         if (icache_ready)
            done = 1'b1;
      end
      icache_en = 1'b0;
      if (!done) begin
         chk("ready_timeout", 128'd0, 128'd1);
         void'(sb_q.pop_front());
      end else begin
         exp_lat = v.hit ? 1 : 1 + 4 * (v.stall + 1);
         chk("latency", 128'(n), 128'(exp_lat));
         chk("mem_req_cycles", 128'(reqc), 128'(v.hit ? 0 : 4 * (v.stall + 1)));
      end
      @(negedge clk);
      chk("ready_pulse_width", {127'd0, icache_ready}, 128'd0);
   endtask

   vec_t vecs[19];

   initial begin
      int n;
      reset          = 1'b0;
      icache_en      = 1'b0;
      icache_address = '0;
      flush          = 1'b0;

      vecs[0]  = mk(32'h0000_1234, 0, 0, 1'b0);
      vecs[0].data = 128'h44444444_33333333_22222222_11111111;
      vecs[1]  = mk(32'h0000_123F, 0, 0, 1'b1);
      vecs[1].data = 128'h44444444_33333333_22222222_11111111;
      vecs[2]  = mk(32'h0000_12B0, 0, 0, 1'b0);
      vecs[3]  = mk(32'h0000_1230, 0, 0, 1'b0);
      vecs[4]  = mk(32'h0000_1238, 0, 0, 1'b1);
      vecs[5]  = mk(32'h0000_2040, 3, 0, 1'b0);
      vecs[6]  = mk(32'h0000_2040, 0, 0, 1'b1);
      vecs[7]  = mk(32'hABCD_0050, 0, 3, 1'b0);
      vecs[8]  = mk(32'hABCD_0050, 0, 0, 1'b0);
      vecs[9]  = mk(32'hABCD_0050, 0, 0, 1'b1);
      vecs[10] = mk(32'hFFFF_FFF0, 0, 0, 1'b0);
      vecs[11] = mk(32'h7FFF_FFF0, 0, 0, 1'b0);
      vecs[12] = mk(32'h7FFF_FFF0, 0, 0, 1'b1);
      vecs[13] = mk(32'h7FFF_FFF0, 0, 2, 1'b1);
      vecs[14] = mk(32'h7FFF_FFF0, 0, 0, 1'b0);
      vecs[15] = mk(32'h0000_2040, 1, 0, 1'b0);
      vecs[16] = mk(32'h0000_2040, 0, 0, 1'b1);
      vecs[17] = mk(32'h0000_2040, 0, 1, 1'b0);
      vecs[18] = mk(32'h0000_1230, 0, 0, 1'b0);

      @(negedge clk);
      @(negedge clk);
      chk("rst_icache_ready", {127'd0, icache_ready}, 128'd0);
      chk("rst_icache_data", icache_data, 128'd0);
      chk("rst_mem_req", {127'd0, mem_req}, 128'd0);
      chk("rst_mem_addr", {96'd0, mem_addr}, 128'd0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 19; i++)
         do_req(vecs[i]);

      // Request held high across the ready pulse: responses come with one idle cycle between them.
      sb_q.push_back(exp_line(32'h0000_1230));
      sb_q.push_back(exp_line(32'h0000_1230));
      icache_en      = 1'b1;
      icache_address = 32'h0000_1230;
      @(negedge clk);
      chk("b2b_ready_0", {127'd0, icache_ready}, 128'd1);
      @(negedge clk);
      chk("b2b_ready_1", {127'd0, icache_ready}, 128'd0);
      @(negedge clk);
      chk("b2b_ready_2", {127'd0, icache_ready}, 128'd1);
      icache_en = 1'b0;
      @(negedge clk);
      chk("b2b_ready_3", {127'd0, icache_ready}, 128'd0);

      // Reset after beat 1 of a fill: bus released at once, line refilled from beat 0 afterwards.
      stall_cycles   = 0;
      cur_line       = 28'h0000567;
      mbeat          = 2'd0;
      icache_en      = 1'b1;
      icache_address = 32'h0000_5670;
      n = 0;
      while (!(mem_req && mem_addr[3:2] == 2'd2) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("midfill_reached_beat2", {127'd0, mem_req}, 128'd1);
      #2 reset = 1'b0;
      #1;
      chk("midfill_rst_mem_req", {127'd0, mem_req}, 128'd0);
      chk("midfill_rst_ready", {127'd0, icache_ready}, 128'd0);
      chk("midfill_rst_mem_addr", {96'd0, mem_addr}, 128'd0);
      icache_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      do_req(mk(32'h0000_5670, 0, 0, 1'b0));
      do_req(mk(32'h0000_5670, 0, 0, 1'b1));

      chk("sb_drained", 128'(sb_q.size()), 128'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
